// File: rtl/branch_predictor_pkg.sv
// Shared opcode, 2-bit counter encoding and saturating-update helper for the
// fetch-stage branch predictor.
package branch_predictor_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        logic [1:0] v;
        v = ctr;
        if (taken) begin
            if (ctr != ST) v = v + 2'd1;
        end else begin
            if (ctr != SNT) v = v - 2'd1;
        end
        return ctr_t'(v);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing signal bundle of the branch predictor: fetch lookup,
// hazard-unit stall/flush and decode-stage resolve.
interface branch_predictor_if;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        pred_takenF;
    logic [31:0] pred_targetF;
    logic        branchD;
    logic        equalD;
    logic [31:0] pcplus4D;
    logic [31:0] pcbranchD;
    logic        pred_takenD;
    logic        mispredictD;
    logic [31:0] redirect_pcD;

    modport master (
        output stallF, stallD, flushD, pcF, instrF,
        output branchD, equalD, pcplus4D, pcbranchD,
        input  pred_takenF, pred_targetF, pred_takenD, mispredictD, redirect_pcD
    );

    modport slave (
        input  stallF, stallD, flushD, pcF, instrF,
        input  branchD, equalD, pcplus4D, pcbranchD,
        output pred_takenF, pred_targetF, pred_takenD, mispredictD, redirect_pcD
    );
endinterface

// File: rtl/branch_predictor_pht.sv
// Pattern history table: 2-bit saturating counters, combinational read for
// fetch lookup, clocked read-modify-write for decode-stage training.
module branch_predictor_pht
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_ridx,
    output ctr_t             o_rctr,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic             i_taken
);
    localparam int N = 1 << IDX_W;

    ctr_t r_pht [N];

    // Same-cycle read of the entry being written returns the old counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) r_pht[i] <= WNT;
        end else if (i_we) begin
            r_pht[i_widx] <= ctr_next(r_pht[i_widx], i_taken);
        end
    end

    assign o_rctr = r_pht[i_ridx];

endmodule

// File: rtl/branch_predictor.sv
// beq direction predictor: fetch predecode + PHT lookup, F->D prediction
// register, decode resolve/update. Define BP_GSHARE_EN for gshare indexing.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    logic                 w_is_brF;
    logic                 w_pred_takenF;
    logic [PHT_IDX_W-1:0] w_idxF;
    logic [31:0]          w_immF;
    ctr_t                 w_ctrF;
    logic                 w_resD;
    logic                 w_actualD;
    logic                 w_unused_instr;

    logic                 r_vldD;
    logic                 r_pred_takenD;
    logic [PHT_IDX_W-1:0] r_idxD;

    assign w_is_brF      = (bp.instrF[31:26] == OP_BEQ);
    assign w_immF        = {{14{bp.instrF[15]}}, bp.instrF[15:0], 2'b00};
    assign w_pred_takenF = w_is_brF & w_ctrF[1];
    assign w_unused_instr = ^bp.instrF[25:16];

    assign bp.pred_takenF  = w_pred_takenF;
    assign bp.pred_targetF = bp.pcF + 32'd4 + w_immF;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]     r_ghr;
    logic [GHR_W-1:0]     r_ghr_snapD;
    logic [PHT_IDX_W-1:0] w_ghr_ext;

    always_comb begin
        w_ghr_ext = '0;
        w_ghr_ext[GHR_W-1:0] = r_ghr;
    end

    assign w_idxF = bp.pcF[PHT_IDX_W+1:2] ^ w_ghr_ext;

    // A mispredict rebuilds history from the branch's own snapshot, which also
    // discards the shift of any wrong-path beq sitting in fetch this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
        end else if (bp.mispredictD) begin
            r_ghr <= {r_ghr_snapD[GHR_W-2:0], w_actualD};
        end else if (w_is_brF && !bp.stallF) begin
            r_ghr <= {r_ghr[GHR_W-2:0], w_pred_takenF};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr_snapD <= '0;
        end else if (!bp.stallD) begin
            r_ghr_snapD <= bp.flushD ? '0 : r_ghr;
        end
    end
`else
    assign w_idxF = bp.pcF[PHT_IDX_W+1:2];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vldD        <= 1'b0;
            r_pred_takenD <= 1'b0;
            r_idxD        <= '0;
        end else if (!bp.stallD) begin
            if (bp.flushD) begin
                r_vldD        <= 1'b0;
                r_pred_takenD <= 1'b0;
                r_idxD        <= '0;
            end else begin
                r_vldD        <= w_is_brF;
                r_pred_takenD <= w_pred_takenF;
                r_idxD        <= w_idxF;
            end
        end
    end

    // Resolving only on the stall-release cycle gives one verdict per branch.
    assign w_resD    = r_vldD & bp.branchD & ~bp.stallD;
    assign w_actualD = bp.equalD;

    assign bp.pred_takenD  = r_pred_takenD;
    assign bp.mispredictD  = w_resD & (r_pred_takenD != w_actualD);
    assign bp.redirect_pcD = w_resD ? (w_actualD ? bp.pcbranchD : bp.pcplus4D) : 32'd0;

    branch_predictor_pht #(
        .IDX_W (PHT_IDX_W)
    ) u_pht (
        .clk     (clk),
        .rst     (rst),
        .i_ridx  (w_idxF),
        .o_rctr  (w_ctrF),
        .i_we    (w_resD),
        .i_widx  (r_idxD),
        .i_taken (w_actualD)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a cycle model pushes expected outputs
// as stimulus is driven; each test task pops and compares them.
module tb_branch_predictor;
    localparam int PHT_IDX_W = 10;
    localparam int GHR_W     = 10;
    localparam int N         = 1 << PHT_IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(
        .PHT_IDX_W (PHT_IDX_W),
        .GHR_W     (GHR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        pt_f;
        logic [31:0] tgt_f;
        logic        pt_d;
        logic        mis;
        logic [31:0] redir;
    } exp_t;
    exp_t exp_q[$];

    logic [1:0]           m_pht [N];
    logic [GHR_W-1:0]     m_ghr;
    logic [GHR_W-1:0]     m_snap;
    logic                 m_vld;
    logic                 m_pt;
    logic [PHT_IDX_W-1:0] m_idx;

    function automatic logic [PHT_IDX_W-1:0] m_idx_of(input logic [31:0] pc);
        logic [PHT_IDX_W-1:0] ix;
        ix = pc[PHT_IDX_W+1:2];
`ifdef BP_GSHARE_EN
        ix = ix ^ PHT_IDX_W'(m_ghr);
`endif
        return ix;
    endfunction

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'b000100, 5'd1, 5'd2, imm};
    endfunction

    always @(posedge clk or negedge rst) begin
        logic                 br, pf, res, act;
        logic [PHT_IDX_W-1:0] ix;
        logic [GHR_W-1:0]     g_old;
        if (!rst) begin
            for (int i = 0; i < N; i++) m_pht[i] = 2'd1;
            m_ghr = '0; m_snap = '0; m_vld = 1'b0; m_pt = 1'b0; m_idx = '0;
        end else begin
            ix    = m_idx_of(bp_if.pcF);
            g_old = m_ghr;
            br    = (bp_if.instrF[31:26] == 6'b000100);
            pf    = br & m_pht[ix][1];
            act   = bp_if.equalD;
            res   = m_vld & bp_if.branchD & ~bp_if.stallD;
            if (res) m_pht[m_idx] = m_sat(m_pht[m_idx], act);
            if (res && (m_pt != act)) m_ghr = {m_snap[GHR_W-2:0], act};
            else if (br && !bp_if.stallF) m_ghr = {m_ghr[GHR_W-2:0], pf};
            if (!bp_if.stallD) begin
                if (bp_if.flushD) begin
                    m_vld = 1'b0; m_pt = 1'b0; m_idx = '0; m_snap = '0;
                end else begin
                    m_vld = br; m_pt = pf; m_idx = ix; m_snap = g_old;
                end
            end
        end
    end

    task automatic push_exp();
        exp_t e;
        logic res;
        e.pt_f  = (bp_if.instrF[31:26] == 6'b000100) & m_pht[m_idx_of(bp_if.pcF)][1];
        e.tgt_f = bp_if.pcF + 32'd4 + {{14{bp_if.instrF[15]}}, bp_if.instrF[15:0], 2'b00};
        e.pt_d  = m_pt;
        res     = m_vld & bp_if.branchD & ~bp_if.stallD;
        e.mis   = res & (m_pt != bp_if.equalD);
        e.redir = bp_if.equalD ? bp_if.pcbranchD : bp_if.pcplus4D;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bp_if.stallF = 1'b0; bp_if.stallD = 1'b0; bp_if.flushD = 1'b0;
        bp_if.pcF = 32'd0; bp_if.instrF = 32'd0;
        bp_if.branchD = 1'b0; bp_if.equalD = 1'b0;
        bp_if.pcplus4D = 32'd0; bp_if.pcbranchD = 32'd0;
    endtask

    task automatic set_f(input logic [31:0] pc, input logic [31:0] instr);
        bp_if.pcF = pc; bp_if.instrF = instr;
    endtask

    task automatic set_d(input logic br, input logic eq, input logic [31:0] p4, input logic [31:0] pb);
        bp_if.branchD = br; bp_if.equalD = eq; bp_if.pcplus4D = p4; bp_if.pcbranchD = pb;
    endtask

    task automatic do_reset();
        tick();
        idle_in();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_in();
        #1;
        set_f(32'h40, beq(16'h0003));
        push_exp();
        #1;
        e = exp_q.pop_front();
        n_run++; if (bp_if.pred_takenF !== 1'b0 || e.pt_f !== 1'b0) begin n_fail++; $display("FAIL reset_pt_f: got %0b want 0", bp_if.pred_takenF); end
        n_run++; if (bp_if.pred_targetF !== 32'h50) begin n_fail++; $display("FAIL reset_tgt: got %0h want 50", bp_if.pred_targetF); end
        n_run++; if (bp_if.pred_takenD !== 1'b0) begin n_fail++; $display("FAIL reset_pt_d: got %0b want 0", bp_if.pred_takenD); end
        n_run++; if (bp_if.mispredictD !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %0b want 0", bp_if.mispredictD); end
        n_run++; if (bp_if.redirect_pcD !== 32'd0) begin n_fail++; $display("FAIL reset_redir: got %0h want 0", bp_if.redirect_pcD); end
        set_f(32'h40, 32'h2001_0005);
        #1;
        n_run++; if (bp_if.pred_takenF !== 1'b0) begin n_fail++; $display("FAIL reset_nonbr: got %0b want 0", bp_if.pred_takenF); end
        idle_in();
        #4;
        rst = 1'b1;
    endtask

    task automatic test_train();
        exp_t e;
        logic act_t [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic hand_pt[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int r = 0; r < 4; r++) begin
            tick();
            set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++; if (bp_if.pred_takenF !== e.pt_f) begin n_fail++; $display("FAIL train_pt_f r%0d: got %0b want %0b", r, bp_if.pred_takenF, e.pt_f); end
`ifndef BP_GSHARE_EN
            n_run++; if (bp_if.pred_takenF !== hand_pt[r]) begin n_fail++; $display("FAIL train_ctr r%0d: got %0b want %0b", r, bp_if.pred_takenF, hand_pt[r]); end
`endif
            tick();
            set_f(32'h44, 32'd0); set_d(1'b1, act_t[r], 32'h44, 32'h50);
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++; if (bp_if.pred_takenD !== e.pt_d) begin n_fail++; $display("FAIL train_pt_d r%0d: got %0b want %0b", r, bp_if.pred_takenD, e.pt_d); end
            n_run++; if (bp_if.mispredictD !== e.mis) begin n_fail++; $display("FAIL train_mis r%0d: got %0b want %0b", r, bp_if.mispredictD, e.mis); end
            if (e.mis) begin
                n_run++; if (bp_if.redirect_pcD !== e.redir) begin n_fail++; $display("FAIL train_redir r%0d: got %0h want %0h", r, bp_if.redirect_pcD, e.redir); end
            end
        end
    endtask

    task automatic test_mispredict();
        exp_t e;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            tick();
            set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++; if (bp_if.pred_takenF !== e.pt_f) begin n_fail++; $display("FAIL mis_pt_f r%0d: got %0b want %0b", r, bp_if.pred_takenF, e.pt_f); end
            tick();
            // Last round resolves not-taken while a wrong-path beq sits in fetch.
            if (r == 2) begin set_f(32'h50, beq(16'h0010)); set_d(1'b1, 1'b0, 32'h44, 32'h50); end
            else        begin set_f(32'h44, 32'd0);         set_d(1'b1, 1'b1, 32'h44, 32'h50); end
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++; if (bp_if.mispredictD !== e.mis) begin n_fail++; $display("FAIL mis_mis r%0d: got %0b want %0b", r, bp_if.mispredictD, e.mis); end
            if (e.mis) begin
                n_run++; if (bp_if.redirect_pcD !== e.redir) begin n_fail++; $display("FAIL mis_redir r%0d: got %0h want %0h", r, bp_if.redirect_pcD, e.redir); end
            end
        end
`ifndef BP_GSHARE_EN
        n_run++; if (bp_if.pred_takenD !== 1'b1 || bp_if.mispredictD !== 1'b1 || bp_if.redirect_pcD !== 32'h44) begin
            n_fail++; $display("FAIL mis_hand: got pt_d=%0b mis=%0b redir=%0h want 1 1 44", bp_if.pred_takenD, bp_if.mispredictD, bp_if.redirect_pcD);
        end
`endif
        tick();
        idle_in();
`ifdef BP_GSHARE_EN
        n_run++; if (dut.r_ghr !== m_ghr) begin n_fail++; $display("FAIL mis_ghr: got %0h want %0h", dut.r_ghr, m_ghr); end
`endif
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            tick(); set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
            tick(); set_f(32'h44, 32'd0);         set_d(1'b1, 1'b1, 32'h44, 32'h50);
        end
        tick(); set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
        for (int s = 0; s < 3; s++) begin
            tick();
            set_f(32'h44, 32'd0); set_d(1'b1, 1'b0, 32'h44, 32'h50);
            bp_if.stallD = (s < 2); bp_if.stallF = (s < 2);
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            if (s < 2) begin
                n_run++; if (bp_if.mispredictD !== 1'b0) begin n_fail++; $display("FAIL stall_hold s%0d: got %0b want 0", s, bp_if.mispredictD); end
            end
            n_run++; if (bp_if.mispredictD !== e.mis) begin n_fail++; $display("FAIL stall_mis s%0d: got %0b want %0b", s, bp_if.mispredictD, e.mis); end
        end
        tick();
        bp_if.stallD = 1'b0; bp_if.stallF = 1'b0;
        set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++; if (bp_if.pred_takenF !== e.pt_f) begin n_fail++; $display("FAIL stall_one_upd: got %0b want %0b", bp_if.pred_takenF, e.pt_f); end
`ifndef BP_GSHARE_EN
        n_run++; if (bp_if.pred_takenF !== 1'b1) begin n_fail++; $display("FAIL stall_ctr_wt: got %0b want 1", bp_if.pred_takenF); end
`endif
    endtask

    task automatic test_flush();
        exp_t e;
        do_reset();
        tick(); set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0); bp_if.flushD = 1'b1;
        tick();
        bp_if.flushD = 1'b0;
        set_f(32'h44, 32'd0); set_d(1'b1, 1'b1, 32'h44, 32'h50);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++; if (bp_if.mispredictD !== 1'b0 || e.mis !== 1'b0) begin n_fail++; $display("FAIL flush_mis: got %0b want 0", bp_if.mispredictD); end
        n_run++; if (bp_if.pred_takenD !== 1'b0) begin n_fail++; $display("FAIL flush_pt_d: got %0b want 0", bp_if.pred_takenD); end
        tick();
        set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++; if (bp_if.pred_takenF !== e.pt_f) begin n_fail++; $display("FAIL flush_no_upd: got %0b want %0b", bp_if.pred_takenF, e.pt_f); end
`ifndef BP_GSHARE_EN
        n_run++; if (bp_if.pred_takenF !== 1'b0) begin n_fail++; $display("FAIL flush_ctr_wnt: got %0b want 0", bp_if.pred_takenF); end
`endif
    endtask

    task automatic test_alias();
        exp_t e;
        logic [31:0] pcs [3] = '{32'h0000_1040, 32'h0000_0044, 32'h0010_0040};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            tick(); set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
            tick(); set_f(32'h44, 32'd0);         set_d(1'b1, 1'b1, 32'h44, 32'h50);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            set_f(pcs[k], beq(16'hFFFE)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
            bp_if.stallF = 1'b1;
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++; if (bp_if.pred_takenF !== e.pt_f) begin n_fail++; $display("FAIL alias_pt_f k%0d: got %0b want %0b", k, bp_if.pred_takenF, e.pt_f); end
            n_run++; if (bp_if.pred_targetF !== e.tgt_f) begin n_fail++; $display("FAIL alias_tgt k%0d: got %0h want %0h", k, bp_if.pred_targetF, e.tgt_f); end
        end
        bp_if.stallF = 1'b0;
`ifndef BP_GSHARE_EN
        n_run++; if (bp_if.pred_takenF !== 1'b1) begin n_fail++; $display("FAIL alias_shared: got %0b want 1", bp_if.pred_takenF); end
`endif
    endtask

    task automatic test_reset_mid();
        exp_t e;
        tick();
        set_f(32'h40, beq(16'h0003)); set_d(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        push_exp();
        e = exp_q.pop_front();
        n_run++; if (bp_if.pred_takenF !== 1'b0 || e.pt_f !== 1'b0) begin n_fail++; $display("FAIL rstmid_pt_f: got %0b want 0", bp_if.pred_takenF); end
        n_run++; if (bp_if.pred_takenD !== 1'b0) begin n_fail++; $display("FAIL rstmid_pt_d: got %0b want 0", bp_if.pred_takenD); end
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] pool [4] = '{32'h40, 32'h80, 32'h1040, 32'hC0};
        logic [31:0] pc, tgt, d_pc, d_tgt;
        logic        stall;
        do_reset();
        pc = 32'h40; tgt = 32'h50; d_pc = 32'h0; d_tgt = 32'h0;
        for (int c = 0; c < 40; c++) begin
            tick();
            stall = ($urandom_range(0, 5) == 0);
            if (!bp_if.stallD) begin
                d_pc = pc; d_tgt = tgt;
                pc = pool[$urandom_range(0, 3)];
                tgt = pc + 32'd4 + {{14{1'b0}}, 4'd0, 12'($urandom_range(0, 255)), 2'b00};
            end
            bp_if.stallD = stall; bp_if.stallF = stall;
            set_f(pc, beq(16'((tgt - pc - 32'd4) >> 2)));
            set_d(1'b1, 1'($urandom_range(0, 1)), d_pc + 32'd4, d_tgt);
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++; if (bp_if.pred_takenF !== e.pt_f) begin n_fail++; $display("FAIL b2b_pt_f c%0d: got %0b want %0b", c, bp_if.pred_takenF, e.pt_f); end
            n_run++; if (bp_if.pred_targetF !== e.tgt_f) begin n_fail++; $display("FAIL b2b_tgt c%0d: got %0h want %0h", c, bp_if.pred_targetF, e.tgt_f); end
            n_run++; if (bp_if.pred_takenD !== e.pt_d) begin n_fail++; $display("FAIL b2b_pt_d c%0d: got %0b want %0b", c, bp_if.pred_takenD, e.pt_d); end
            n_run++; if (bp_if.mispredictD !== e.mis) begin n_fail++; $display("FAIL b2b_mis c%0d: got %0b want %0b", c, bp_if.mispredictD, e.mis); end
            if (e.mis) begin
                n_run++; if (bp_if.redirect_pcD !== e.redir) begin n_fail++; $display("FAIL b2b_redir c%0d: got %0h want %0h", c, bp_if.redirect_pcD, e.redir); end
            end
        end
        tick();
        idle_in();
    endtask

    initial begin
        test_reset();
        test_train();
        test_mispredict();
        test_stall();
        test_flush();
        test_alias();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, run=%0d failed=%0d", n_run, n_fail);
        $fatal(1);
    end

endmodule
